// File: rtl/dlatch_monitor.sv
// Clocked checker for a D-latch: registers D/C/Q/Q_n, tracks a zero-delay
// reference latch and reports Q mismatch / Q_n complement violations.
module dlatch_monitor #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             c,
  input  logic             q,
  input  logic             q_n,
  output logic [1:0]       state,
  output logic             ref_q,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] open_cnt
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

  typedef enum logic [1:0] {
    UNKNOWN     = 2'b00,
    TRANSPARENT = 2'b01,
    HOLD        = 2'b10
  } state_t;

  state_t         cur, nxt;
  logic           d_r, c_r, q_r, qn_r, c_prev;
  logic [SW-1:0]  settle_cnt;
  logic           expv, armed, arm_rise, qerr, cerr;

  always_comb begin
    nxt = cur;
    case (cur)
      UNKNOWN:     if (c_r)  nxt = TRANSPARENT;
      TRANSPARENT: if (!c_r) nxt = HOLD;
      HOLD:        if (c_r)  nxt = TRANSPARENT;
      default:     nxt = UNKNOWN;
    endcase
  end

  // Armed only rises on the first transparent sample after reset.
  always_comb begin
    expv     = c_r ? d_r : ref_q;
    armed    = (cur != UNKNOWN) || c_r;
    arm_rise = (cur == UNKNOWN) && c_r;
    qerr     = armed && (settle_cnt >= SETTLE_V) && (q_r != expv);
    cerr     = armed && (q_r == qn_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r          <= 1'b0;
      c_r          <= 1'b0;
      q_r          <= 1'b0;
      qn_r         <= 1'b0;
      c_prev       <= 1'b0;
      cur          <= UNKNOWN;
      ref_q        <= 1'b0;
      settle_cnt   <= '0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      mismatch_cnt <= '0;
      open_cnt     <= '0;
    end else begin
      d_r    <= d;
      c_r    <= c;
      q_r    <= q;
      qn_r   <= q_n;
      c_prev <= c_r;
      cur    <= nxt;
      ref_q  <= expv;
      if (expv != ref_q || arm_rise) settle_cnt <= '0;
      else if (settle_cnt < SETTLE_V) settle_cnt <= settle_cnt + 1'b1;
      if (qerr || cerr) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (!err) begin
          err      <= 1'b1;
          err_code <= {cerr, qerr};
        end
      end
      if (c_r && !c_prev) open_cnt <= open_cnt + 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_dlatch_monitor.sv
// Scoreboard bench: a behavioural latch-checker model predicts every cycle's
// outputs for an 8-bit and a 4-bit counter instance driven by the same pins.
module tb_dlatch_monitor;

  logic clk, rst, d, c, q, q_n;
  logic [1:0] state8, code8, state4, code4;
  logic refq8, err8, refq4, err4;
  logic [7:0] mcnt8, ocnt8;
  logic [3:0] mcnt4, ocnt4;

  dlatch_monitor #(.SETTLE(1), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .d(d), .c(c), .q(q), .q_n(q_n),
    .state(state8), .ref_q(refq8), .err(err8), .err_code(code8),
    .mismatch_cnt(mcnt8), .open_cnt(ocnt8));

  dlatch_monitor #(.SETTLE(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .d(d), .c(c), .q(q), .q_n(q_n),
    .state(state4), .ref_q(refq4), .err(err4), .err_code(code4),
    .mismatch_cnt(mcnt4), .open_cnt(ocnt4));

  localparam int SETTLE = 1;

  typedef struct {
    int seen, refv, since, err, code, mcnt, ocnt, lastc;
  } mdl_t;

  typedef struct {
    int   due;
    mdl_t a;
    mdl_t b;
  } sb_t;

  sb_t  sb[$];
  mdl_t ma, mb;
  int   cyc, n_chk, n_fail;
  bit   pd, pc, pq, pqn, lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
    end
  endtask

  // Reference: one processed sample of the checker, by the rules of a latch.
  function automatic mdl_t mstep(mdl_t m, bit sd, bit sc, bit sq, bit sqn, int w);
    bit armed, e, qe, ce;
    armed = (m.seen != 0) || sc;
    e     = sc ? sd : bit'(m.refv);
    qe    = armed && (m.since >= SETTLE) && (sq != e);
    ce    = armed && (sq == sqn);
    if (e != m.refv || (sc && m.seen == 0)) m.since = 0;
    else m.since++;
    if (qe || ce) begin
      if (m.mcnt < (1 << w) - 1) m.mcnt++;
      if (m.err == 0) begin
        m.err  = 1;
        m.code = (ce ? 2 : 0) + (qe ? 1 : 0);
      end
    end
    if (sc && m.lastc == 0) m.ocnt = (m.ocnt + 1) % (1 << w);
    m.lastc = sc;
    m.refv  = e;
    if (sc) m.seen = 1;
    return m;
  endfunction

  function automatic int mstate(mdl_t m);
    return (m.seen == 0) ? 0 : (m.lastc != 0 ? 1 : 2);
  endfunction

  task automatic step(input bit sd, input bit sc, input bit sq, input bit sqn, input bit r);
    sb_t e;
    @(negedge clk); #1;
    d = sd; c = sc; q = sq; q_n = sqn; rst = r;
    if (r) begin
      ma = '{default: 0};
      mb = '{default: 0};
      {pd, pc, pq, pqn} = 4'b0;
    end else begin
      ma = mstep(ma, pd, pc, pq, pqn, 8);
      mb = mstep(mb, pd, pc, pq, pqn, 4);
      {pd, pc, pq, pqn} = {sd, sc, sq, sqn};
    end
    e.due = cyc + 1; e.a = ma; e.b = mb;
    sb.push_back(e);
  endtask

  // Pins from a well-behaved latch.
  task automatic gstep(input bit sd, input bit sc, input bit r);
    if (sc) lat = sd;
    step(sd, sc, lat, ~lat, r);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) gstep(d, c, 1'b0);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check("state8", state8, mstate(e.a));
      check("ref_q8", refq8, e.a.refv);
      check("err8",   err8,   e.a.err);
      check("code8",  code8,  e.a.code);
      check("mcnt8",  mcnt8,  e.a.mcnt);
      check("ocnt8",  ocnt8,  e.a.ocnt);
      check("state4", state4, mstate(e.b));
      check("ref_q4", refq4, e.b.refv);
      check("err4",   err4,   e.b.err);
      check("code4",  code4,  e.b.code);
      check("mcnt4",  mcnt4,  e.b.mcnt);
      check("ocnt4",  ocnt4,  e.b.ocnt);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, cc;
    cyc = 0; n_chk = 0; n_fail = 0; lat = 0;
    d = 0; c = 0; q = 0; q_n = 0; rst = 1;
    ma = '{default: 0}; mb = '{default: 0};

    // reset with random pins
    repeat (2) step(bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom), 1'b1);
    gstep(0, 0, 0);
    check("rst_state", state8, 0);
    check("rst_err", err8, 0);
    check("rst_ocnt", ocnt8, 0);

    // correct latch, three pulses
    ld = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) begin ld = bit'($urandom); gstep(ld, 1, 0); end
      for (int i = 0; i < 10; i++) gstep(bit'($urandom), 0, 0);
    end
    flush(3);
    check("good_err", err8, 0);
    check("good_mcnt", mcnt8, 0);
    check("good_ocnt", ocnt8, 3);
    check("good_state", state8, 2);
    check("good_refq", refq8, ld);

    // transparency fault: Q stuck at 0 while D rises
    gstep(0, 1, 1);
    repeat (4) gstep(0, 1, 0);
    repeat (5) step(1, 1, 0, 1, 0);
    repeat (3) gstep(1, 1, 0);
    check("tr_mcnt", mcnt8, 4);
    check("tr_err", err8, 1);
    check("tr_code", code8, 1);

    // hold fault: Q follows D while C low
    repeat (3) gstep(0, 1, 0);
    repeat (2) gstep(0, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0);
    check("hold_mcnt", mcnt8, 7);
    check("hold_code", code8, 1);
    check("hold_state", state8, 2);

    // complement error then sticky code, then mid-run reset
    gstep(1, 1, 1);
    repeat (3) gstep(1, 1, 0);
    step(1, 1, 1, 1, 0);
    repeat (2) step(1, 1, 0, 1, 0);
    repeat (2) gstep(1, 1, 0);
    check("cmp_code", code8, 2);
    check("cmp_mcnt", mcnt8, 3);
    gstep(1, 1, 1);
    gstep(1, 1, 0);
    check("mid_rst_err", err8, 0);
    check("mid_rst_mcnt", mcnt8, 0);

    // saturation: continuous complement violation
    gstep(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      bit b;
      b = bit'($urandom);
      step(bit'($urandom), 1, b, b, 0);
    end
    flush(3);
    check("sat_mcnt4", mcnt4, 15);
    check("sat_mcnt8", mcnt8, 20);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 0);
    flush(3);
    check("sat_mcnt8_max", mcnt8, 255);

    // open_cnt wrap
    gstep(0, 0, 1);
    for (int p = 0; p < 17; p++) begin
      gstep(bit'($urandom), 1, 0);
      gstep(bit'($urandom), 0, 0);
    end
    flush(3);
    check("wrap_ocnt4", ocnt4, 1);
    check("wrap_ocnt8", ocnt8, 17);

    // random mix of good and faulty latch behaviour
    cc = 0;
    for (int i = 0; i < 500; i++) begin
      bit r, dd;
      r  = ($urandom_range(0, 59) == 0);
      dd = bit'($urandom);
      if ($urandom_range(0, 3) == 0) cc = ~cc;
      if ($urandom_range(0, 9) < 7) gstep(dd, cc, r);
      else step(dd, cc, bit'($urandom), bit'($urandom), r);
    end
    flush(3);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
